// File: rtl/sargantana_icache_inval_ctrl_pkg.sv
// Shared icache definitions for the invalidation sequencer: state encoding and geometry defaults.
package sargantana_icache_inval_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WALK  = 2'd2,
        DONE  = 2'd3
    } inval_state_t;

    localparam int ICACHE_N_WAY_DEF = 4;
    localparam int ICACHE_DEPTH_DEF = 64;
    localparam int ICACHE_IDX_W_DEF = $clog2(ICACHE_DEPTH_DEF);

endpackage

// File: rtl/sargantana_icache_inval_ctrl_if.sv
// Fill-side write request and valid-array write port, bundled as one interface.
interface sargantana_icache_inval_ctrl_if
    import sargantana_icache_inval_ctrl_pkg::*;
#(
    parameter int N_WAY = ICACHE_N_WAY_DEF,
    parameter int IDX_W = ICACHE_IDX_W_DEF
);
    logic             fill_we_i;
    logic [IDX_W-1:0] fill_idx_i;
    logic [N_WAY-1:0] fill_way_i;
    logic             vld_we_o;
    logic [IDX_W-1:0] vld_idx_o;
    logic [N_WAY-1:0] vld_way_mask_o;
    logic             vld_bit_o;

    // slave: the sequencer/arbiter; master: fill controller plus valid array
    modport slave (
        input  fill_we_i, fill_idx_i, fill_way_i,
        output vld_we_o, vld_idx_o, vld_way_mask_o, vld_bit_o
    );
    modport master (
        output fill_we_i, fill_idx_i, fill_way_i,
        input  vld_we_o, vld_idx_o, vld_way_mask_o, vld_bit_o
    );
endinterface

// File: rtl/sargantana_icache_inval_ctrl.sv
// Icache flush sequencer and valid-array write-port arbiter (fill pass-through vs. set walk).
// Optional: ICACHE_INVAL_ON_RESET_EN makes reset start a full invalidation walk.
module sargantana_icache_inval_ctrl
    import sargantana_icache_inval_ctrl_pkg::*;
#(
    parameter int ICACHE_N_WAY = ICACHE_N_WAY_DEF,
    parameter int ICACHE_DEPTH = ICACHE_DEPTH_DEF,
    parameter int IDX_W        = $clog2(ICACHE_DEPTH)
)(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic flush_req_i,
    input  logic ifill_pending_i,
    sargantana_icache_inval_ctrl_if.slave vld_if,
    output logic busy_o,
    output logic core_block_o,
    output logic flush_done_o,
    output logic fill_drop_o
);

`ifdef ICACHE_INVAL_ON_RESET_EN
    localparam inval_state_t RST_STATE = WALK;
`else
    localparam inval_state_t RST_STATE = IDLE;
`endif

    inval_state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic                    w_we, w_bit, w_done, w_drop;
    logic [IDX_W-1:0]        w_idx;
    logic [ICACHE_N_WAY-1:0] w_mask;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= RST_STATE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_we        = 1'b0;
        w_idx       = '0;
        w_mask      = '0;
        w_bit       = 1'b0;
        w_done      = 1'b0;
        w_drop      = 1'b0;

        // Outside a walk the fill controller owns the write port.
        if ((r_state == IDLE || r_state == DRAIN) && vld_if.fill_we_i) begin
            w_we   = 1'b1;
            w_idx  = vld_if.fill_idx_i;
            w_mask = vld_if.fill_way_i;
            w_bit  = 1'b1;
        end

        unique case (r_state)
            IDLE, DONE: begin
                w_done = (r_state == DONE);
                w_drop = (r_state == DONE) && vld_if.fill_we_i;
                if (flush_req_i) begin
                    if (ifill_pending_i) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_state_nxt = WALK;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (!ifill_pending_i) begin
                    w_state_nxt = WALK;
                    w_idx_nxt   = '0;
                end
            end
            WALK: begin
                // Flush requests arriving here are absorbed: the walk covers every set anyway.
                w_we      = 1'b1;
                w_idx     = r_idx;
                w_mask    = '1;
                w_bit     = 1'b0;
                w_drop    = vld_if.fill_we_i;
                w_idx_nxt = r_idx + IDX_W'(1);
                if (r_idx == IDX_W'(ICACHE_DEPTH - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign vld_if.vld_we_o       = w_we;
    assign vld_if.vld_idx_o      = w_idx;
    assign vld_if.vld_way_mask_o = w_mask;
    assign vld_if.vld_bit_o      = w_bit;

    assign busy_o       = (r_state != IDLE);
    assign core_block_o = (r_state == WALK) || (r_state == DONE);
    assign flush_done_o = w_done;
    assign fill_drop_o  = w_drop;

endmodule

// File: tb/tb_sargantana_icache_inval_ctrl.sv
// Directed bench for the icache invalidation sequencer (DEPTH=64, 4 ways).
module tb_sargantana_icache_inval_ctrl;
    import sargantana_icache_inval_ctrl_pkg::*;

    localparam int NW    = 4;
    localparam int DEPTH = 64;
    localparam int IW    = 6;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    logic flush_req_i = 1'b0;
    logic ifill_pending_i = 1'b0;
    logic busy_o, core_block_o, flush_done_o, fill_drop_o;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int d1 = 0;
    int d2 = 0;

    sargantana_icache_inval_ctrl_if #(.N_WAY(NW), .IDX_W(IW)) bus();

    sargantana_icache_inval_ctrl #(
        .ICACHE_N_WAY (NW),
        .ICACHE_DEPTH (DEPTH),
        .IDX_W        (IW)
    ) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .flush_req_i     (flush_req_i),
        .ifill_pending_i (ifill_pending_i),
        .vld_if          (bus),
        .busy_o          (busy_o),
        .core_block_o    (core_block_o),
        .flush_done_o    (flush_done_o),
        .fill_drop_o     (fill_drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // {we, bit, mask, idx}
    function automatic logic [31:0] ev(input logic we, input logic b, input logic [3:0] m,
                                       input logic [5:0] ix);
        return {20'b0, we, b, m, ix};
    endfunction

    function automatic logic [31:0] vpk();
        return {20'b0, bus.vld_we_o, bus.vld_bit_o, bus.vld_way_mask_o, bus.vld_idx_o};
    endfunction

    // {busy, core_block, done, drop}
    function automatic logic [31:0] st();
        return {28'b0, busy_o, core_block_o, flush_done_o, fill_drop_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        cyc++;
        #2;
    endtask

    // Checks walk writes from idx 0; injects a fill at drop_at, returns early at stop_at.
    task automatic walk(input int drop_at, input int stop_at);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == stop_at) return;
            if (i == drop_at) begin
                bus.fill_we_i  = 1'b1;
                bus.fill_idx_i = 6'd5;
                bus.fill_way_i = 4'b0001;
                #1;
                chk("walk_drop", st(), 32'b1101);
            end else begin
                chk("walk_st", st(), 32'b1100);
            end
            chk("walk_wr", vpk(), ev(1'b1, 1'b0, 4'hF, IW'(i)));
            bus.fill_we_i = 1'b0;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bus.fill_we_i  = 1'b0;
        bus.fill_idx_i = '0;
        bus.fill_way_i = '0;
        #3;
`ifdef ICACHE_INVAL_ON_RESET_EN
        chk("rst_st", st(), 32'b1100);
        chk("rst_vld", vpk(), ev(1'b1, 1'b0, 4'hF, 6'd0));
        #14 rstn_i = 1'b1;
        walk(-1, DEPTH);
        chk("rst_walk_done", st(), 32'b1110);
        tick();
`else
        chk("rst_st", st(), 32'b0);
        chk("rst_vld", vpk(), 32'b0);
        #14 rstn_i = 1'b1;
        tick();
        tick();
        chk("idle_st", st(), 32'b0);
        chk("idle_vld", vpk(), 32'b0);
`endif

        // Plain flush, no pending fill
        flush_req_i = 1'b1;
        #1;
        chk("req_idle", st(), 32'b0);
        tick();
        flush_req_i = 1'b0;
        #1;
        walk(-1, DEPTH);
        chk("done1", st(), 32'b1110);
        chk("done1_vld", vpk(), 32'b0);
        tick();
        chk("back_idle", st(), 32'b0);

        // Flush while an IFILL is outstanding; fill passes through during DRAIN
        flush_req_i = 1'b1;
        ifill_pending_i = 1'b1;
        tick();
        flush_req_i = 1'b0;
        #1;
        chk("drain_st", st(), 32'b1000);
        chk("drain_vld", vpk(), 32'b0);
        tick(); tick(); tick();
        bus.fill_we_i  = 1'b1;
        bus.fill_idx_i = 6'd7;
        bus.fill_way_i = 4'b0010;
        #1;
        chk("drain_fill", vpk(), ev(1'b1, 1'b1, 4'b0010, 6'd7));
        chk("drain_nodrop", st(), 32'b1000);
        tick();
        bus.fill_we_i = 1'b0;
        tick(); tick(); tick();
        ifill_pending_i = 1'b0;
        #1;
        chk("drain_last", vpk(), 32'b0);
        tick();
        walk(20, DEPTH);
        bus.fill_we_i = 1'b1;
        #1;
        chk("done_drop", st(), 32'b1111);
        chk("done_nowr", vpk(), 32'b0);
        bus.fill_we_i = 1'b0;
        tick();
        chk("idle2", st(), 32'b0);

        // Request held across DONE: back-to-back walks
        flush_req_i = 1'b1;
        tick();
        walk(-1, DEPTH);
        d1 = cyc;
        chk("bb_done1", st(), 32'b1110);
        tick();
        walk(-1, DEPTH);
        d2 = cyc;
        chk("bb_done2", st(), 32'b1110);
        chk("done_gap", 32'(d2 - d1), 32'd65);

        // DONE with request and pending fill goes to DRAIN
        ifill_pending_i = 1'b1;
        #1;
        tick();
        chk("done_to_drain", st(), 32'b1000);
        flush_req_i = 1'b0;
        ifill_pending_i = 1'b0;
        #1;
        tick();

        // Reset mid-walk at idx 30
        walk(-1, 30);
        chk("pre_rst_idx", vpk(), ev(1'b1, 1'b0, 4'hF, 6'd30));
        rstn_i = 1'b0;
        #1;
`ifdef ICACHE_INVAL_ON_RESET_EN
        chk("rst_mid_st", st(), 32'b1100);
        chk("rst_mid_vld", vpk(), ev(1'b1, 1'b0, 4'hF, 6'd0));
        #3 rstn_i = 1'b1;
        walk(-1, DEPTH);
        chk("rst_mid_done", st(), 32'b1110);
        tick();
        chk("rst_mid_idle", st(), 32'b0);
`else
        chk("rst_mid_st", st(), 32'b0);
        chk("rst_mid_vld", vpk(), 32'b0);
        #3 rstn_i = 1'b1;
        tick();
        tick();
        chk("post_rst_st", st(), 32'b0);
        chk("post_rst_vld", vpk(), 32'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_inval_ctrl.md
# sargantana_icache_inval_ctrl

Invalidation sequencer and valid-array port arbiter for the instruction cache. On a flush request it waits for any outstanding IFILL to drain, then walks every set and clears all way valid bits, one set per cycle. It signals completion back to the cache controller with a one-cycle done pulse. Outside a walk it passes IFILL valid-bit writes straight through to the single valid-array write port, so fill and flush share that port without conflict.

## Interface
Parameters:
- ICACHE_N_WAY, 4, number of ways (valid bits per set)
- ICACHE_DEPTH, 64, number of sets; power of two, ≥2
- IDX_W, $clog2(ICACHE_DEPTH), set index width (derived)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- flush_req_i  in  1  flush request, sampled every cycle, level or pulse
- ifill_pending_i  in  1  IFILL request outstanding to the upper level
- fill_we_i  in  1  fill controller writes a valid bit
- fill_idx_i  in  IDX_W  fill set index
- fill_way_i  in  ICACHE_N_WAY  one-hot fill way
- vld_we_o  out  1  valid-array write enable
- vld_idx_o  out  IDX_W  valid-array set index
- vld_way_mask_o  out  ICACHE_N_WAY  ways written
- vld_bit_o  out  1  value written (1 = fill, 0 = invalidate)
- busy_o  out  1  sequencer is in DRAIN, WALK or DONE
- core_block_o  out  1  core lookups must be held off (WALK or DONE)
- flush_done_o  out  1  one-cycle completion pulse
- fill_drop_o  out  1  fill write discarded because a walk is active

## Operation
States: IDLE, DRAIN, WALK, DONE. Index counter idx_q is IDX_W bits wide.
- IDLE: when flush_req_i is high:
  - ifill_pending_i high → DRAIN.
  - otherwise → WALK, with idx_q set to 0.
- DRAIN: when ifill_pending_i goes low → WALK, with idx_q set to 0. Fills are still passed through in DRAIN.
- WALK: each cycle drive vld_we_o=1, vld_idx_o=idx_q, vld_way_mask_o=all ones, vld_bit_o=0, then increment idx_q.
  - When idx_q = ICACHE_DEPTH-1 → DONE.
  - No wrap-around: idx_q is reloaded on WALK entry.
- DONE: flush_done_o=1 for exactly this cycle.
  - flush_req_i high → DRAIN or WALK, using the same rule as IDLE.
  - otherwise → IDLE.
- Fill pass-through (IDLE, DRAIN): vld_we_o=fill_we_i, vld_idx_o=fill_idx_i, vld_way_mask_o=fill_way_i, vld_bit_o=1.
- Fill during WALK or DONE: fill_we_i is discarded and fill_drop_o=fill_we_i in the same cycle. The array is not written by the fill.
- flush_req_i during DRAIN or WALK: merged into the current flush, no restart. A walk already covers every set, and fills are blocked while it runs.
- Idle outputs (IDLE, DRAIN with no fill): vld_we_o=0; vld_idx_o, vld_way_mask_o and vld_bit_o=0.

## Timing
- Reset values: state IDLE (see Configuration), idx_q=0. All outputs 0 except where the configured reset state drives them.
- Latency, flush_req_i to first invalidate write:
  - 1 cycle when no IFILL is pending.
  - 1 cycle after ifill_pending_i falls when draining.
- Walk length is exactly ICACHE_DEPTH cycles. flush_done_o follows the last write by 1 cycle.
- Total flush with no pending fill is ICACHE_DEPTH+2 cycles from request to return to IDLE.
- All outputs are combinational from state_q/idx_q plus the fill inputs. There is no output register.
- Reset asserted mid-walk: returns immediately to the reset state. No done pulse is produced for the aborted walk.

## Configuration
- ICACHE_INVAL_ON_RESET_EN defined:
  - Reset state is WALK with idx_q=0, so the array is cleared after every reset.
  - busy_o=1 and core_block_o=1 from reset release.
  - flush_done_o pulses at the end of this walk.
- ICACHE_INVAL_ON_RESET_EN undefined: reset state is IDLE, and the array contents after reset are left to the memory or to an explicit flush.

## Structure
- A shared icache package holds:
  - the state enum inval_state_t {IDLE, DRAIN, WALK, DONE}, logic[1:0]
  - ICACHE_N_WAY and ICACHE_DEPTH defaults
  - the index-width localparam
- No sub-module is needed. The arbiter is a 2:1 mux; a single FSM plus counter fits in one file.

## Test plan
- DEPTH=64, idle, flush_req_i pulse with no pending fill → WALK next cycle; 64 writes with idx 0..63, mask 4'b1111, bit 0; flush_done_o pulses at cycle 66; then IDLE.
- flush_req_i with ifill_pending_i=1 for 10 cycles, fill_we_i at cycle 5 (idx 7, way 4'b0010) → fill is written with bit 1; walk starts 1 cycle after pending drops.
- fill_we_i asserted during WALK at idx 20 → fill_drop_o=1 that cycle; vld_idx_o=20 with bit 0; the fill is not written.
- flush_req_i held high across DONE → second walk starts immediately; two done pulses separated by 65 cycles.
- rstn_i asserted at idx 30 → outputs 0 at once; with ICACHE_INVAL_ON_RESET_EN the walk restarts at idx 0 on release and completes all 64 sets.
- Macro undefined: after reset, vld_we_o=0 and busy_o=0 until the first flush request.
